// File: rtl/wrr_age_arbiter_pkg.sv
// wrr_arb_pkg: shared definitions for the weighted aging arbiter.
//   - default parameter constants
//   - arbiter state encoding (IDLE / GRANT)
//   - sat_add(): saturating age + increment, clamped to 2^width-1
package wrr_arb_pkg;

    localparam int unsigned N_REQ_DEF = 4;
    localparam int unsigned AGE_W_DEF = 8;
    localparam int unsigned INC_W_DEF = 4;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    // Operands are widened to 32 bits so one function serves any AGE_W/INC_W;
    // the caller narrows the result back to AGE_W.
    function automatic logic [31:0] sat_add(input logic [31:0] age,
                                            input logic [31:0] inc,
                                            input int unsigned width);
        logic [32:0] sum;
        logic [32:0] lim;
        sum = {1'b0, age} + {1'b0, inc};
        lim = (33'd1 << width) - 33'd1;
        return (sum > lim) ? lim[31:0] : sum[31:0];
    endfunction

endpackage

// File: rtl/wrr_age_arbiter_if.sv
// wrr_age_arbiter_if: request/ack bundle between N upstream masters, the
// arbiter and the single downstream slave port.
//   req_in/ack_in     per-channel request level / one-hot acknowledge
//   weight_cfg        per-channel age increment, INC_W bits each
//   req_out/ack_out   downstream request (registered) / acknowledge
//   gnt_idx           index of the granted channel (registered)
//   lock_in           per-channel bus lock, only when ARB_LOCK_EN is defined
// Modports: slave = arbiter side, master = environment side.
interface wrr_age_arbiter_if
    import wrr_arb_pkg::*;
#(
    parameter int unsigned N_REQ = N_REQ_DEF,
    parameter int unsigned INC_W = INC_W_DEF
);
    localparam int unsigned IDX_W = $clog2(N_REQ);

    logic [N_REQ-1:0]       req_in;
    logic [N_REQ-1:0]       ack_in;
    logic [N_REQ*INC_W-1:0] weight_cfg;
    logic                   req_out;
    logic                   ack_out;
    logic [IDX_W-1:0]       gnt_idx;
`ifdef ARB_LOCK_EN
    logic [N_REQ-1:0]       lock_in;
`endif

    modport slave (
`ifdef ARB_LOCK_EN
        input  lock_in,
`endif
        input  req_in, weight_cfg, ack_out,
        output ack_in, req_out, gnt_idx
    );

    modport master (
`ifdef ARB_LOCK_EN
        output lock_in,
`endif
        output req_in, weight_cfg, ack_out,
        input  ack_in, req_out, gnt_idx
    );

endinterface

// File: rtl/wrr_age_arbiter_age_max_sel.sv
// age_max_sel: combinational N-way argmax over ages with lowest-index
// tie-break.
//   i_age    packed per-channel ages
//   i_valid  per-channel candidate mask
//   o_idx    index of the oldest valid candidate (0 when none)
//   o_any    at least one candidate valid
module age_max_sel #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned AGE_W = 8
) (
    input  logic [N_REQ-1:0][AGE_W-1:0] i_age,
    input  logic [N_REQ-1:0]            i_valid,
    output logic [$clog2(N_REQ)-1:0]    o_idx,
    output logic                        o_any
);
    localparam int unsigned IDX_W = $clog2(N_REQ);

    logic [IDX_W-1:0] w_idx;
    logic [AGE_W-1:0] w_best;
    logic             w_any;

    // Strict '>' keeps the earlier (lower) index on equal ages.
    always_comb begin
        w_idx  = '0;
        w_best = '0;
        w_any  = 1'b0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (i_valid[i] && (!w_any || (i_age[i] > w_best))) begin
                w_any  = 1'b1;
                w_idx  = IDX_W'(i);
                w_best = i_age[i];
            end
        end
    end

    assign o_idx = w_idx;
    assign o_any = w_any;

endmodule

// File: rtl/wrr_age_arbiter.sv
// wrr_age_arbiter: N-way weighted aging arbiter. Every requesting channel's
// age grows by its weight each cycle (saturating); the oldest requester is
// granted and the grant is held until the transfer fires or the requester
// withdraws. A fired channel's age is cleared.
//   clk, rstn  clock, asynchronous active-low reset
//   arb_if     wrr_age_arbiter_if.slave (req/ack in, req/ack out, gnt_idx)
// Optional macro ARB_LOCK_EN: adds lock_in; a fire with the granted channel
// locked keeps the grant and its age so bursts are not interleaved.
module wrr_age_arbiter
    import wrr_arb_pkg::*;
#(
    parameter int unsigned N_REQ = N_REQ_DEF,
    parameter int unsigned AGE_W = AGE_W_DEF,
    parameter int unsigned INC_W = INC_W_DEF
) (
    input  logic               clk,
    input  logic               rstn,
    wrr_age_arbiter_if.slave   arb_if
);
    localparam int unsigned IDX_W = $clog2(N_REQ);

    arb_state_e                  r_state;
    logic [IDX_W-1:0]            r_gnt;
    logic [N_REQ-1:0][AGE_W-1:0] r_age;

    logic [N_REQ-1:0][AGE_W-1:0] w_next_age;
    logic [N_REQ-1:0][AGE_W-1:0] w_cand_age;
    logic [N_REQ-1:0]            w_gnt_oh;
    logic                        w_gnt_req;
    logic                        w_fire;
    logic                        w_lock_hold;
    logic                        w_clear;
    logic                        w_others;
    logic [IDX_W-1:0]            w_win;
    logic                        w_any;

    always_comb begin
        for (int unsigned i = 0; i < N_REQ; i++) begin
            w_next_age[i] = arb_if.req_in[i]
                ? AGE_W'(sat_add(32'(r_age[i]),
                                 32'(arb_if.weight_cfg[i*INC_W +: INC_W]),
                                 AGE_W))
                : r_age[i];
        end
    end

    always_comb begin
        w_gnt_oh        = '0;
        w_gnt_oh[r_gnt] = 1'b1;
    end

    assign w_gnt_req = |(arb_if.req_in & w_gnt_oh);
    assign w_fire    = (r_state == GRANT) && arb_if.ack_out && w_gnt_req;
    assign w_others  = |(arb_if.req_in & ~w_gnt_oh);

`ifdef ARB_LOCK_EN
    assign w_lock_hold = w_fire && |(arb_if.lock_in & w_gnt_oh);
`else
    assign w_lock_hold = 1'b0;
`endif

    assign w_clear = w_fire && !w_lock_hold;

    // The channel being acked competes with age 0 in the re-arbitration
    // of the same cycle, matching the value its age register takes.
    always_comb begin
        for (int unsigned i = 0; i < N_REQ; i++) begin
            w_cand_age[i] = (w_clear && w_gnt_oh[i]) ? '0 : w_next_age[i];
        end
    end

    age_max_sel #(
        .N_REQ (N_REQ),
        .AGE_W (AGE_W)
    ) u_sel (
        .i_age   (w_cand_age),
        .i_valid (arb_if.req_in),
        .o_idx   (w_win),
        .o_any   (w_any)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
            r_gnt   <= '0;
            r_age   <= '0;
        end else begin
            r_age <= w_cand_age;
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_state <= GRANT;
                        r_gnt   <= w_win;
                    end
                end
                GRANT: begin
                    if (w_lock_hold) begin
                        r_gnt <= r_gnt;
                    end else if (w_fire) begin
                        if (w_others) r_gnt   <= w_win;
                        else          r_state <= IDLE;
                    end else if (!w_gnt_req) begin
                        if (w_any) r_gnt   <= w_win;
                        else       r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign arb_if.req_out = (r_state == GRANT);
    assign arb_if.gnt_idx = r_gnt;
    assign arb_if.ack_in  = w_fire ? w_gnt_oh : '0;

endmodule
